apb3_master_arbiter: RTL and testbench

//  Shares one APB3 slave port between N_REQ requesters via round-robin arbitration.

---
 rtl/apb3_master_arbiter_if.sv | 24 ++
 rtl/apb3_master_arbiter.sv | 160 ++++++++++++++++
 tb/tb_apb3_master_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb3_master_arbiter_if.sv
// APB3 bus between the arbitrating master and one slave.
interface apb3_master_arbiter_if #(
    parameter int N_BIT_DATA    = 32,
    parameter int N_BIT_ADDRESS = 32
);
    logic                     PSEL;
    logic                     PENABLE;
    logic                     PWRITE;
    logic [N_BIT_ADDRESS-1:0] PADDR;
    logic [N_BIT_DATA-1:0]    PWDATA;
    logic [N_BIT_DATA-1:0]    PRDATA;
    logic                     PREADY;
    logic                     PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb3_master_arbiter.sv
// Round-robin arbiter sharing one APB3 slave among N_REQ requesters.
// Sequences IDLE/SETUP/ACCESS, honours wait states and aborts hung transfers.
module apb3_master_arbiter #(
    parameter int N_BIT_DATA     = 32,
    parameter int N_BIT_ADDRESS  = 32,
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0]               req_write,
    input  logic [N_REQ*N_BIT_ADDRESS-1:0] req_addr,
    input  logic [N_REQ*N_BIT_DATA-1:0]    req_wdata,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [N_BIT_DATA-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic [1:0]                     dbg_state,
    apb3_master_arbiter_if.master          apb
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                   r_state,     w_state;
    logic [GW-1:0]            r_grant,     w_grant;
    logic [GW-1:0]            r_ptr,       w_ptr;
    logic [CW-1:0]            r_cnt,       w_cnt;
    logic                     r_psel,      w_psel;
    logic                     r_penable,   w_penable;
    logic                     r_pwrite,    w_pwrite;
    logic [N_BIT_ADDRESS-1:0] r_paddr,     w_paddr;
    logic [N_BIT_DATA-1:0]    r_pwdata,    w_pwdata;
    logic [N_REQ-1:0]         r_rsp_valid, w_rsp_valid;
    logic [N_BIT_DATA-1:0]    r_rsp_rdata, w_rsp_rdata;
    logic                     r_rsp_err,   w_rsp_err;

    logic [N_REQ-1:0]         w_eligible;
    logic                     w_found;
    logic [GW-1:0]            w_pick;
    int                       w_idx;

    // A requester whose completion pulse is on the bus this cycle is still
    // holding req_valid; masking it prevents re-granting the finished transfer.
    always_comb begin
        w_eligible = req_valid & ~r_rsp_valid;
        w_found    = 1'b0;
        w_pick     = '0;
        w_idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state     = r_state;
        w_grant     = r_grant;
        w_ptr       = r_ptr;
        w_cnt       = r_cnt;
        w_psel      = r_psel;
        w_penable   = r_penable;
        w_pwrite    = r_pwrite;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;
        w_rsp_valid = '0;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state   = ST_SETUP;
                    w_grant   = w_pick;
                    w_ptr     = (int'(w_pick) == N_REQ - 1) ? '0 : w_pick + GW'(1);
                    w_psel    = 1'b1;
                    w_penable = 1'b0;
                    w_pwrite  = req_write[w_pick];
                    w_paddr   = req_addr[int'(w_pick)*N_BIT_ADDRESS +: N_BIT_ADDRESS];
                    w_pwdata  = req_wdata[int'(w_pick)*N_BIT_DATA +: N_BIT_DATA];
                end
            end
            ST_SETUP: begin
                w_state   = ST_ACCESS;
                w_penable = 1'b1;
                w_cnt     = CW'(1);
            end
            ST_ACCESS: begin
                if (apb.PREADY) begin
                    w_state              = ST_IDLE;
                    w_psel               = 1'b0;
                    w_penable            = 1'b0;
                    w_cnt                = '0;
                    w_rsp_valid[r_grant] = 1'b1;
                    w_rsp_rdata          = r_pwrite ? '0 : apb.PRDATA;
                    w_rsp_err            = apb.PSLVERR;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES))) begin
                    w_state              = ST_IDLE;
                    w_psel               = 1'b0;
                    w_penable            = 1'b0;
                    w_cnt                = '0;
                    w_rsp_valid[r_grant] = 1'b1;
                    w_rsp_rdata          = '0;
                    w_rsp_err            = 1'b1;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_grant     <= w_grant;
            r_ptr       <= w_ptr;
            r_cnt       <= w_cnt;
            r_psel      <= w_psel;
            r_penable   <= w_penable;
            r_pwrite    <= w_pwrite;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
        end
    end

    assign apb.PSEL    = r_psel;
    assign apb.PENABLE = r_penable;
    assign apb.PWRITE  = r_pwrite;
    assign apb.PADDR   = r_paddr;
    assign apb.PWDATA  = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Directed bench for apb3_master_arbiter: bench plays both requesters and the APB slave.
module tb_apb3_master_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 2;

    logic              PCLK;
    logic              PRESETn;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_q[$];
    logic [1:0] prev_rsp;
    int         acc_cycles;

    apb3_master_arbiter_if #(.N_BIT_DATA(DW), .N_BIT_ADDRESS(AW)) apb ();

    apb3_master_arbiter #(
        .N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .N_REQ(NR), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dbg_state(dbg_state),
        .apb(apb.master)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Return 1 time unit after a rising edge: outputs are settled, inputs safe to change.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[idx]          = wr;
        req_addr[idx*AW +: AW]  = a;
        req_wdata[idx*DW +: DW] = d;
    endtask

    initial begin
        PRESETn     = 1'b0;
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        apb.PRDATA  = '0;
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b0;
        step();
        step();
        check("rst_psel",    apb.PSEL, 0);
        check("rst_penable", apb.PENABLE, 0);
        check("rst_paddr",   apb.PADDR, 0);
        check("rst_pwdata",  apb.PWDATA, 0);
        check("rst_rsp",     rsp_valid, 0);
        check("rst_rdata",   rsp_rdata, 0);
        check("rst_err",     rsp_err, 0);
        check("rst_state",   dbg_state, 0);

        // Write from req0, zero wait states
        PRESETn = 1'b1;
        set_req(0, 1'b1, 32'h10, 32'hA5A5_A5A5);
        req_valid = 2'b01;
        step();
        check("t1_setup_psel",    apb.PSEL, 1);
        check("t1_setup_penable", apb.PENABLE, 0);
        check("t1_paddr",         apb.PADDR, 32'h10);
        check("t1_pwrite",        apb.PWRITE, 1);
        check("t1_pwdata",        apb.PWDATA, 32'hA5A5_A5A5);
        step();
        check("t1_access_penable", apb.PENABLE, 1);
        check("t1_access_rsp",     rsp_valid, 0);
        step();
        check("t1_done_psel", apb.PSEL, 0);
        check("t1_rsp",       rsp_valid, 2'b01);
        check("t1_err",       rsp_err, 0);
        check("t1_rdata",     rsp_rdata, 0);
        req_valid = 2'b00;
        step();
        check("t1_rsp_pulse", rsp_valid, 0);
        check("t1_idle_psel", apb.PSEL, 0);

        // Read from req1 with three wait states; request fields change after latch
        set_req(1, 1'b0, 32'h04, 32'h0);
        req_valid  = 2'b10;
        apb.PREADY = 1'b0;
        apb.PRDATA = 32'h1234_5678;
        step();
        check("t2_setup_paddr", apb.PADDR, 32'h04);
        check("t2_pwrite",      apb.PWRITE, 0);
        step();
        check("t2_acc1_penable", apb.PENABLE, 1);
        set_req(1, 1'b1, 32'hFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_wait_penable", apb.PENABLE, 1);
            check("t2_wait_paddr",   apb.PADDR, 32'h04);
            check("t2_wait_pwrite",  apb.PWRITE, 0);
            check("t2_wait_rsp",     rsp_valid, 0);
        end
        apb.PREADY = 1'b1;
        step();
        check("t2_rsp",   rsp_valid, 2'b10);
        check("t2_rdata", rsp_rdata, 32'h1234_5678);
        check("t2_err",   rsp_err, 0);
        check("t2_psel",  apb.PSEL, 0);
        req_valid = 2'b00;
        step();

        // PSLVERR sampled with PREADY
        set_req(0, 1'b0, 32'h30, 32'h0);
        req_valid   = 2'b01;
        apb.PSLVERR = 1'b1;
        apb.PRDATA  = 32'hCAFE_F00D;
        step();
        step();
        step();
        check("t5a_rsp",   rsp_valid, 2'b01);
        check("t5a_err",   rsp_err, 1);
        check("t5a_rdata", rsp_rdata, 32'hCAFE_F00D);
        req_valid = 2'b00;
        step();
        // PSLVERR while PREADY low must be ignored
        set_req(1, 1'b0, 32'h34, 32'h0);
        req_valid  = 2'b10;
        apb.PREADY = 1'b0;
        step();
        step();
        step();
        check("t5b_wait_rsp", rsp_valid, 0);
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b0;
        step();
        check("t5b_rsp", rsp_valid, 2'b10);
        check("t5b_err", rsp_err, 0);
        req_valid = 2'b00;
        step();

        // Timeout with PREADY stuck low
        set_req(0, 1'b0, 32'h20, 32'h0);
        req_valid  = 2'b01;
        apb.PREADY = 1'b0;
        apb.PRDATA = 32'hDEAD_BEEF;
        step();
        step();
        acc_cycles = (apb.PENABLE === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (apb.PENABLE !== 1'b1) break;
            acc_cycles++;
        end
        check("t4_access_cycles", acc_cycles, 16);
        check("t4_psel",          apb.PSEL, 0);
        check("t4_rsp",           rsp_valid, 2'b01);
        check("t4_err",           rsp_err, 1);
        check("t4_rdata",         rsp_rdata, 0);
        req_valid  = 2'b00;
        apb.PREADY = 1'b1;
        step();

        // Both requesters held valid from reset: strict alternation
        PRESETn = 1'b0;
        set_req(0, 1'b0, 32'h100, 32'h0);
        set_req(1, 1'b0, 32'h200, 32'h0);
        req_valid  = 2'b11;
        apb.PRDATA = 32'h5555_AAAA;
        step();
        PRESETn  = 1'b1;
        exp_q    = {2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        prev_rsp = 2'b00;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            step();
            if (prev_rsp != 2'b00) check("t3_rsp_one_cycle", rsp_valid, 0);
            if (rsp_valid != 2'b00) check("t3_rr_order", rsp_valid, exp_q.pop_front());
            prev_rsp = rsp_valid;
        end
        req_valid = 2'b00;
        check("t3_all_grants", exp_q.size(), 0);
        step();

        // Reset during ACCESS of a req1 transfer
        PRESETn = 1'b0;
        step();
        PRESETn = 1'b1;
        set_req(0, 1'b0, 32'h88, 32'h0);
        set_req(1, 1'b0, 32'h44, 32'h0);
        req_valid  = 2'b10;
        apb.PREADY = 1'b0;
        step();
        check("t6_setup_paddr", apb.PADDR, 32'h44);
        step();
        check("t6_access_penable", apb.PENABLE, 1);
        PRESETn   = 1'b0;
        req_valid = 2'b11;
        step();
        check("t6_rst_psel",    apb.PSEL, 0);
        check("t6_rst_penable", apb.PENABLE, 0);
        check("t6_rst_rsp",     rsp_valid, 0);
        check("t6_rst_state",   dbg_state, 0);
        PRESETn    = 1'b1;
        apb.PREADY = 1'b1;
        step();
        check("t6_grant_psel",  apb.PSEL, 1);
        check("t6_grant_paddr", apb.PADDR, 32'h88);
        check("t6_no_rsp",      rsp_valid, 0);
        step();
        step();
        check("t6_rsp", rsp_valid, 2'b01);
        req_valid = 2'b00;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
